// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man video fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: layer_t (pixel layer code), fetch_state_t (scheduler FSM),
// layer_mask_t (pending-layer bits), geometry constants, default ROM bases
// and a priority helper.
package pacman_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        PACMAN = 2'b01,
        DOT    = 2'b10,
        MAZE   = 2'b11
    } layer_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        WAIT  = 2'b10
    } fetch_state_t;

    // Field order matches the priority order, highest first.
    typedef struct packed {
        logic pacman;
        logic dot;
        logic maze;
    } layer_mask_t;

    localparam int unsigned MAZE_W  = 640;
    localparam int unsigned SPR_DIM = 16;
    localparam int unsigned DOT_DIM = 8;

    localparam int unsigned DEF_ADDR_W      = 19;
    localparam int unsigned DEF_MAZE_BASE   = 0;
    localparam int unsigned DEF_PACMAN_BASE = 307200;
    localparam int unsigned DEF_DOT_BASE    = 308224;

    // Highest-priority layer still pending; NONE when the mask is empty.
    function automatic layer_t top_layer(input layer_mask_t m);
        if (m.pacman) begin
            return PACMAN;
        end else if (m.dot) begin
            return DOT;
        end else if (m.maze) begin
            return MAZE;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/pixel_fetch_sched_if.sv
// Bundle between the pixel pipeline / ROM side and the fetch scheduler.
// Latency: n/a (wires only).
// Backpressure: none; pix_start is a pulse and the ROM answers in fixed time.
//
// master: drives pixel request (pix_start, coordinates, flags, sprite state)
//         and ROM read data; observes ROM strobe/address and resolved pixel.
// slave : the scheduler.
interface pixel_fetch_sched_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              pix_start;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              is_pacman;
    logic              is_dot;
    logic              is_maze;
    logic [9:0]        pacman_x;
    logic [9:0]        pacman_y;
    logic [1:0]        pacman_frame;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0]        rom_data;
    logic              pix_valid;
    logic [1:0]        pix_layer;
    logic [1:0]        pix_data;
    logic              overrun;

    modport master (
        output pix_start, DrawX, DrawY, is_pacman, is_dot, is_maze,
               pacman_x, pacman_y, pacman_frame, rom_data,
        input  rom_rd, rom_addr, pix_valid, pix_layer, pix_data, overrun
    );

    modport slave (
        input  pix_start, DrawX, DrawY, is_pacman, is_dot, is_maze,
               pacman_x, pacman_y, pacman_frame, rom_data,
        output rom_rd, rom_addr, pix_valid, pix_layer, pix_data, overrun
    );

endinterface

// File: rtl/pix_addr_gen.sv
// Candidate ROM word addresses for the maze, pacman and dot layers of a pixel.
// Latency: combinational.
// Backpressure: none.
//
// Ports: DrawX/DrawY pixel coordinates; pacman_x/pacman_y sprite top-left;
// pacman_frame animation frame; maze_addr/pacman_addr/dot_addr outputs,
// all sums truncated to ADDR_W.
module pix_addr_gen
    import pacman_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned MAZE_BASE   = DEF_MAZE_BASE,
    parameter int unsigned PACMAN_BASE = DEF_PACMAN_BASE,
    parameter int unsigned DOT_BASE    = DEF_DOT_BASE
) (
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        pacman_x,
    input  logic [9:0]        pacman_y,
    input  logic [1:0]        pacman_frame,
    output logic [ADDR_W-1:0] maze_addr,
    output logic [ADDR_W-1:0] pacman_addr,
    output logic [ADDR_W-1:0] dot_addr
);

    localparam int SPR_BITS = $clog2(SPR_DIM);
    localparam int DOT_BITS = $clog2(DOT_DIM);
    // Row stride 640 = 512 + 128, so the multiply becomes two shifts.
    localparam int MAZE_SH_HI = $clog2(MAZE_W) - 1;
    localparam int MAZE_SH_LO = $clog2(MAZE_W - (1 << MAZE_SH_HI));

    logic [SPR_BITS-1:0] dx;
    logic [SPR_BITS-1:0] dy;

    // Offsets inside the sprite wrap modulo its size; the caller only asks
    // for the pacman layer when the pixel is actually inside the sprite.
    assign dx = SPR_BITS'(DrawX - pacman_x);
    assign dy = SPR_BITS'(DrawY - pacman_y);

    assign maze_addr = ADDR_W'(MAZE_BASE)
                     + (ADDR_W'(DrawY) << MAZE_SH_HI)
                     + (ADDR_W'(DrawY) << MAZE_SH_LO)
                     + ADDR_W'(DrawX);

    // {frame, dy, dx} == frame*256 + dy*16 + dx for a 16x16 sprite.
    assign pacman_addr = ADDR_W'(PACMAN_BASE)
                       + ADDR_W'({pacman_frame, dy, dx});

    // The dot tile repeats every 8 pixels in both directions.
    assign dot_addr = ADDR_W'(DOT_BASE)
                    + ADDR_W'({DrawY[DOT_BITS-1:0], DrawX[DOT_BITS-1:0]});

endmodule

// File: rtl/pixel_fetch_sched.sv
// Per-pixel layer fetch scheduler: reads ROM texels in priority order
// pacman > dot > maze, falling through on transparent (00) texels.
// Latency: 1 cycle with no layer hit, else 2*fetches+1 cycles from pix_start.
// Backpressure: none; a pix_start while busy abandons the current pixel and
// sets the sticky overrun flag.
//
// Ports: Clk, Reset (synchronous, active-high); bus (slave modport):
// pixel request in, ROM strobe/address out with data one cycle later,
// resolved {pix_layer, pix_data} out with a one-cycle pix_valid pulse.
module pixel_fetch_sched
    import pacman_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned MAZE_BASE   = DEF_MAZE_BASE,
    parameter int unsigned PACMAN_BASE = DEF_PACMAN_BASE,
    parameter int unsigned DOT_BASE    = DEF_DOT_BASE
) (
    input  logic               Clk,
    input  logic               Reset,
    pixel_fetch_sched_if.slave bus
);

    fetch_state_t      state, state_nxt;
    layer_mask_t       mask, mask_nxt, req_mask, work_mask;
    logic [ADDR_W-1:0] gen_maze, gen_pac, gen_dot;
    logic [ADDR_W-1:0] maze_q, pac_q, dot_q;
    logic [ADDR_W-1:0] maze_nxt, pac_nxt, dot_nxt;
    logic [ADDR_W-1:0] work_maze, work_pac, work_dot;
    logic [ADDR_W-1:0] fetch_addr;
    layer_t            pick;
    layer_t            cur_layer, cur_layer_nxt;
    logic              go_fetch;

    logic              rom_rd_q, rom_rd_nxt;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_nxt;
    logic              pix_valid_q, pix_valid_nxt;
    layer_t            pix_layer_q, pix_layer_nxt;
    logic [1:0]        pix_data_q, pix_data_nxt;
    logic              overrun_q, overrun_nxt;

    pix_addr_gen #(
        .ADDR_W      (ADDR_W),
        .MAZE_BASE   (MAZE_BASE),
        .PACMAN_BASE (PACMAN_BASE),
        .DOT_BASE    (DOT_BASE)
    ) u_addr_gen (
        .DrawX        (bus.DrawX),
        .DrawY        (bus.DrawY),
        .pacman_x     (bus.pacman_x),
        .pacman_y     (bus.pacman_y),
        .pacman_frame (bus.pacman_frame),
        .maze_addr    (gen_maze),
        .pacman_addr  (gen_pac),
        .dot_addr     (gen_dot)
    );

    assign req_mask = {bus.is_pacman, bus.is_dot, bus.is_maze};

    // FETCH is the cycle in which rom_rd is high. Because rom_rd/rom_addr
    // are registered, the read is set up (address chosen, mask bit cleared)
    // on the transition into FETCH, not while sitting in it.
    always_comb begin
        state_nxt     = state;
        mask_nxt      = mask;
        maze_nxt      = maze_q;
        pac_nxt       = pac_q;
        dot_nxt       = dot_q;
        cur_layer_nxt = cur_layer;
        rom_rd_nxt    = 1'b0;
        rom_addr_nxt  = rom_addr_q;
        pix_valid_nxt = 1'b0;
        pix_layer_nxt = pix_layer_q;
        pix_data_nxt  = pix_data_q;
        overrun_nxt   = overrun_q;
        work_mask     = mask;
        work_maze     = maze_q;
        work_pac      = pac_q;
        work_dot      = dot_q;
        go_fetch      = 1'b0;
        pick          = NONE;
        fetch_addr    = '0;

        if (bus.pix_start) begin
            // A new pixel always wins; any read still in flight is
            // dropped and its data is never sampled.
            if (state != IDLE) begin
                overrun_nxt = 1'b1;
            end
            work_mask = req_mask;
            work_maze = gen_maze;
            work_pac  = gen_pac;
            work_dot  = gen_dot;
            mask_nxt  = req_mask;
            maze_nxt  = gen_maze;
            pac_nxt   = gen_pac;
            dot_nxt   = gen_dot;
            if (req_mask == '0) begin
                state_nxt     = IDLE;
                pix_valid_nxt = 1'b1;
                pix_layer_nxt = NONE;
                pix_data_nxt  = 2'b00;
            end else begin
                go_fetch = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                FETCH: begin
                    state_nxt = WAIT;
                end
                WAIT: begin
                    // Opaque texel, or nothing left underneath: resolve
                    // with whatever was just read (00 if all transparent).
                    if ((bus.rom_data != 2'b00) || (mask == '0)) begin
                        state_nxt     = IDLE;
                        pix_valid_nxt = 1'b1;
                        pix_layer_nxt = cur_layer;
                        pix_data_nxt  = bus.rom_data;
                    end else begin
                        go_fetch = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        pick = top_layer(work_mask);
        case (pick)
            PACMAN:  fetch_addr = work_pac;
            DOT:     fetch_addr = work_dot;
            MAZE:    fetch_addr = work_maze;
            default: fetch_addr = work_maze;
        endcase

        if (go_fetch) begin
            state_nxt     = FETCH;
            rom_rd_nxt    = 1'b1;
            rom_addr_nxt  = fetch_addr;
            cur_layer_nxt = pick;
            mask_nxt      = work_mask;
            case (pick)
                PACMAN:  mask_nxt.pacman = 1'b0;
                DOT:     mask_nxt.dot    = 1'b0;
                MAZE:    mask_nxt.maze   = 1'b0;
                default: mask_nxt        = work_mask;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            mask        <= '0;
            maze_q      <= '0;
            pac_q       <= '0;
            dot_q       <= '0;
            cur_layer   <= NONE;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_layer_q <= NONE;
            pix_data_q  <= 2'b00;
            overrun_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mask        <= mask_nxt;
            maze_q      <= maze_nxt;
            pac_q       <= pac_nxt;
            dot_q       <= dot_nxt;
            cur_layer   <= cur_layer_nxt;
            rom_rd_q    <= rom_rd_nxt;
            rom_addr_q  <= rom_addr_nxt;
            pix_valid_q <= pix_valid_nxt;
            pix_layer_q <= pix_layer_nxt;
            pix_data_q  <= pix_data_nxt;
            overrun_q   <= overrun_nxt;
        end
    end

    assign bus.rom_rd    = rom_rd_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_layer = pix_layer_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_pixel_fetch_sched.sv
// Bench for pixel_fetch_sched: directed scenarios plus randomized pixels
// checked against a layer-walk reference model and a small ROM table.
module tb_pixel_fetch_sched;

    localparam int          ADDR_W    = 19;
    localparam int unsigned MAZE_B    = 0;
    localparam int unsigned PAC_B     = 307200;
    localparam int unsigned DOT_B     = 308224;

    logic Clk;
    logic Reset;

    pixel_fetch_sched_if #(.ADDR_W(ADDR_W)) bus ();

    pixel_fetch_sched #(
        .ADDR_W      (ADDR_W),
        .MAZE_BASE   (MAZE_B),
        .PACMAN_BASE (PAC_B),
        .DOT_BASE    (DOT_B)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int          total;
    int          bad;
    logic [1:0]  rom [int unsigned];
    int unsigned rd_log [$];
    int          last_layer;
    int          last_data;
    bit          exp_overrun;
    bit          busy;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Word address of a layer's texel for a pixel, straight from the ROM map.
    function automatic int unsigned model_addr(input int layer, input int x, input int y,
                                               input int px, input int py, input int fr);
        int unsigned a;
        case (layer)
            1:       a = PAC_B + fr * 256 + ((y - py) & 15) * 16 + ((x - px) & 15);
            2:       a = DOT_B + (y % 8) * 8 + (x % 8);
            default: a = MAZE_B + y * 640 + x;
        endcase
        return a;
    endfunction

    task automatic scramble();
        bus.DrawX        = 10'($urandom);
        bus.DrawY        = 10'($urandom);
        bus.pacman_x     = 10'($urandom);
        bus.pacman_y     = 10'($urandom);
        bus.pacman_frame = 2'($urandom);
        bus.is_pacman    = 1'($urandom);
        bus.is_dot       = 1'($urandom);
        bus.is_maze      = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            bus.rom_data = 2'($urandom);
            chk("idle_valid", bus.pix_valid, 0);
            chk("idle_rd", bus.rom_rd, 0);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, ":rom_rd"},    bus.rom_rd, 0);
        chk({nm, ":rom_addr"},  bus.rom_addr, 0);
        chk({nm, ":pix_valid"}, bus.pix_valid, 0);
        chk({nm, ":pix_layer"}, bus.pix_layer, 0);
        chk({nm, ":pix_data"},  bus.pix_data, 0);
        chk({nm, ":overrun"},   bus.overrun, 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset       = 1'b0;
        busy        = 1'b0;
        exp_overrun = 1'b0;
        last_layer  = 0;
        last_data   = 0;
    endtask

    // Called #1 after a rising edge; that cycle is cycle 0 of the pixel.
    // fl = {pacman, dot, maze}. Returns in the pix_valid cycle, or in cycle
    // abort_at (when 1 <= abort_at < expected latency) with the DUT busy.
    task automatic run_pixel(input int x, input int y, input int px, input int py,
                             input int fr, input bit [2:0] fl,
                             input logic [1:0] t_pac, input logic [1:0] t_dot,
                             input logic [1:0] t_maze, input int abort_at,
                             input string nm, output bit aborted);
        int unsigned exp_addr [$];
        int          exp_layer;
        int          exp_data;
        int          lat;
        int          ab;
        int          nrd;
        bit          done;
        bit          prev_rd;
        int unsigned prev_addr;
        bit          en  [1:3];
        logic [1:0]  tex [1:3];

        en[1] = fl[2]; en[2] = fl[1]; en[3] = fl[0];
        tex[1] = t_pac; tex[2] = t_dot; tex[3] = t_maze;
        exp_layer = 0;
        exp_data  = 0;
        for (int l = 1; l <= 3; l++) begin
            if (en[l]) begin
                int unsigned a;
                a = model_addr(l, x, y, px, py, fr);
                exp_addr.push_back(a);
                rom[a]    = tex[l];
                exp_layer = l;
                exp_data  = int'(tex[l]);
                if (tex[l] != 2'b00) break;
            end
        end
        lat = (exp_addr.size() == 0) ? 1 : 2 * exp_addr.size() + 1;
        ab  = (abort_at >= 1 && abort_at < lat) ? abort_at : 0;

        if (busy) exp_overrun = 1'b1;
        busy = 1'b1;
        rd_log.delete();

        bus.pix_start    = 1'b1;
        bus.DrawX        = 10'(x);
        bus.DrawY        = 10'(y);
        bus.pacman_x     = 10'(px);
        bus.pacman_y     = 10'(py);
        bus.pacman_frame = 2'(fr);
        bus.is_pacman    = fl[2];
        bus.is_dot       = fl[1];
        bus.is_maze      = fl[0];
        @(posedge Clk);
        #1;
        bus.pix_start = 1'b0;
        scramble();

        nrd       = 0;
        done      = 1'b0;
        aborted   = 1'b0;
        prev_rd   = 1'b0;
        prev_addr = 0;
        for (int c = 1; c <= 20; c++) begin
            if (prev_rd) bus.rom_data = rom.exists(prev_addr) ? rom[prev_addr] : 2'b11;
            else         bus.rom_data = 2'($urandom);
            if (bus.rom_rd) begin
                chk({nm, ":rd_gap"}, prev_rd, 0);
                if (nrd < exp_addr.size()) chk({nm, ":rd_addr"}, bus.rom_addr, exp_addr[nrd]);
                else                       chk({nm, ":extra_rd"}, nrd + 1, exp_addr.size());
                rd_log.push_back(int'(bus.rom_addr));
                nrd++;
            end
            if (bus.pix_valid) begin
                chk({nm, ":latency"}, c, lat);
                chk({nm, ":layer"}, bus.pix_layer, exp_layer);
                chk({nm, ":data"}, bus.pix_data, exp_data);
                chk({nm, ":reads"}, nrd, exp_addr.size());
                chk({nm, ":overrun"}, bus.overrun, exp_overrun);
                last_layer = exp_layer;
                last_data  = exp_data;
                busy       = 1'b0;
                done       = 1'b1;
                break;
            end
            chk({nm, ":layer_hold"}, bus.pix_layer, last_layer);
            chk({nm, ":data_hold"}, bus.pix_data, last_data);
            if (c == ab) begin
                aborted = 1'b1;
                break;
            end
            prev_rd   = bus.rom_rd;
            prev_addr = bus.rom_addr;
            @(posedge Clk);
            #1;
        end
        if (!aborted) chk({nm, ":resolved"}, done, 1);
    endtask

    function automatic int unsigned rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        bit ab;
        total       = 0;
        bad         = 0;
        last_layer  = 0;
        last_data   = 0;
        exp_overrun = 1'b0;
        busy        = 1'b0;
        Reset         = 1'b1;
        bus.pix_start = 1'b0;
        bus.rom_data  = 2'b00;
        scramble();
        repeat (3) @(posedge Clk);
        #1;
        check_reset_vals("reset");
        Reset = 1'b0;
        idle(2);

        run_pixel(10, 20, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0, "none", ab);
        idle(3);

        run_pixel(5, 2, 0, 0, 0, 3'b001, 2'b00, 2'b00, 2'b01, 0, "maze", ab);
        chk("maze:first_addr", rd_at(0), 1285);
        idle(2);

        run_pixel(103, 52, 100, 50, 1, 3'b101, 2'b00, 2'b00, 2'b10, 0, "pac_maze", ab);
        chk("pac_maze:first_addr", rd_at(0), 307491);
        chk("pac_maze:second_addr", rd_at(1), 33383);
        idle(2);

        run_pixel(200, 300, 190, 290, 3, 3'b111, 2'b00, 2'b00, 2'b00, 0, "all3", ab);
        chk("all3:nreads", rd_log.size(), 3);
        idle(2);

        run_pixel(13, 6, 0, 0, 0, 3'b010, 2'b00, 2'b10, 2'b00, 0, "dot", ab);
        chk("dot:first_addr", rd_at(0), 308277);
        idle(2);

        // Second pixel arrives in cycle 2 (WAIT) of a pacman fetch.
        run_pixel(103, 52, 100, 50, 2, 3'b100, 2'b01, 2'b00, 2'b00, 2, "ovr_a", ab);
        chk("ovr_a:aborted", ab, 1);
        chk("ovr_a:overrun_before", bus.overrun, 0);
        run_pixel(40, 40, 0, 0, 0, 3'b001, 2'b00, 2'b00, 2'b11, 0, "ovr_b", ab);
        idle(2);
        chk("ovr:sticky", bus.overrun, 1);
        do_reset();
        check_reset_vals("reset_clr");

        // Reset lands while the second of three reads is on the bus.
        run_pixel(300, 100, 295, 95, 0, 3'b111, 2'b00, 2'b00, 2'b01, 3, "rst_mid", ab);
        do_reset();
        check_reset_vals("reset_mid");
        idle(8);

        for (int n = 0; n < 300; n++) begin
            int          x, y, abort_at;
            bit [2:0]    fl;
            logic [1:0]  tp, td, tm;
            x  = int'($urandom_range(0, 639));
            y  = int'($urandom_range(0, 479));
            fl = 3'($urandom);
            tp = ($urandom % 2 == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            td = ($urandom % 2 == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            tm = ($urandom % 2 == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            abort_at = ($urandom % 8 == 0) ? int'($urandom_range(1, 6)) : 0;
            run_pixel(x, y, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 3)), fl, tp, td, tm, abort_at, "rand", ab);
            if (!ab) idle(int'($urandom_range(0, 3)));
        end
        run_pixel(1, 1, 0, 0, 0, 3'b011, 2'b00, 2'b01, 2'b10, 0, "final", ab);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_fetch_sched.md
# pixel_fetch_sched

Single-port sprite/maze ROM fetch scheduler for the Pac-Man video path. For each pixel it takes the layer-hit flags (pacman, dot, maze) and decides which layer to fetch, in priority order. It issues ROM reads one layer at a time and falls through to the next layer when a fetched texel is transparent (00). It presents one resolved {layer, 2-bit texel} per pixel to the color mapper, held stable between pixels.

## Interface
Parameters:
- ADDR_W, 19, ROM address width
- MAZE_BASE, 0, word address of the 640x480 maze bitmap (row-major)
- PACMAN_BASE, 307200, word address of 4 frames of 16x16 pacman sprite (1024 words)
- DOT_BASE, 308224, word address of the 8x8 dot tile (64 words)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- pix_start  in  1  one-cycle pulse; DrawX/DrawY/flags/pacman_* valid this cycle
- DrawX, DrawY  in  10 each  current pixel coordinates
- is_pacman, is_dot, is_maze  in  1 each  layer hit flags for this pixel
- pacman_x, pacman_y  in  10 each  sprite top-left
- pacman_frame  in  2  animation frame index
- rom_rd  out  1  read strobe (registered)
- rom_addr  out  ADDR_W  read address (registered)
- rom_data  in  2  texel, valid the cycle after rom_rd
- pix_valid  out  1  one-cycle pulse: pix_layer/pix_data updated
- pix_layer  out  2  00 none, 01 pacman, 10 dot, 11 maze; held until next pix_valid
- pix_data  out  2  resolved texel; held until next pix_valid
- overrun  out  1  sticky; pix_start arrived while busy

## Operation
- Reset values: state IDLE, rom_rd 0, rom_addr 0, pix_valid 0, pix_layer 00, pix_data 00, overrun 0.
- Accept: on pix_start, latch a 3-bit pending mask {pacman, dot, maze} and the three candidate addresses.
- Priority: pacman > dot > maze.
- FSM states: IDLE, FETCH, WAIT.
  - IDLE + pix_start, mask empty: stay IDLE. Next cycle pix_valid=1, layer 00, data 00.
  - IDLE + pix_start, mask non-empty: go to FETCH.
  - FETCH: rom_rd=1, rom_addr = address of the highest pending layer. Clear that mask bit. Go to WAIT.
  - WAIT: sample rom_data.
    - Data ≠ 00, or mask now empty: go to IDLE with pix_valid=1, pix_layer = the fetched layer, pix_data = rom_data. An all-transparent pixel therefore reports the last layer fetched (maze if set) with data 00.
    - Otherwise: go to FETCH for the next layer.
- Address arithmetic, all sums truncated to ADDR_W:
  - maze = MAZE_BASE + DrawY·640 + DrawX, computed as (DrawY<<9)+(DrawY<<7)+DrawX.
  - pacman = PACMAN_BASE + frame·256 + dy·16 + dx, where dy = (DrawY−pacman_y)[3:0] and dx = (DrawX−pacman_x)[3:0].
  - dot = DOT_BASE + DrawY[2:0]·8 + DrawX[2:0].
- Overrun: pix_start in FETCH or WAIT abandons the current pixel.
  - No pix_valid is produced for the abandoned pixel.
  - overrun is set to 1 and held until Reset.
  - The new pixel is accepted exactly as from IDLE.
  - A stale rom_data from the abandoned read is never sampled.
- pix_start in the same cycle that pix_valid is high is a legal accept.
- Reset mid-operation: return to reset values next cycle; no pix_valid for the in-flight pixel.

## Timing
Cycle 0 is the cycle in which pix_start is sampled.
- No flags: pix_valid in cycle 1.
- First fetch resolves: rom_rd in cycle 1, rom_data in cycle 2, pix_valid in cycle 3.
- Each transparent fall-through adds 2 cycles: 2 fetches → cycle 5; 3 fetches → cycle 7.
- At most one rom_rd every 2 cycles; rom_rd is never high two cycles in a row.
- pix_start spacing ≥ 7 cycles never overruns. With Clk at 8x the pixel clock there is always margin.
- pix_layer/pix_data change only in the pix_valid cycle.

## Structure
- Shared package pacman_pkg holds:
  - layer_t enum (NONE, PACMAN, DOT, MAZE)
  - MAZE_W=640, SPR_DIM=16, DOT_DIM=8
  - default base-address constants
- Sub-module pix_addr_gen: purely combinational; DrawX/DrawY/pacman_*/frame → three candidate addresses.
- FSM, mask, output registers and overrun live in pixel_fetch_sched.

## Test plan
- Reset then idle: all outputs 0; pix_start with no flags → pix_valid cycle 1, layer 00, data 00, rom_rd never high.
- Maze only, DrawX=5, DrawY=2, ROM returns 01 → rom_addr=1285 in cycle 1; pix_valid cycle 3, layer 11, data 01.
- Pacman+maze, pacman_x=100, pacman_y=50, DrawX=103, DrawY=52, frame=1:
  - First rom_addr = 307200+256+32+3 = 307491.
  - ROM returns 00, so the second fetch reads the maze address 52·640+103 = 33383.
  - ROM returns 10 → pix_valid cycle 5, layer 11, data 10.
- All three flags, ROM returns 00,00,00 → three reads (pacman, dot, maze); pix_valid cycle 7, layer 11, data 00.
- Dot at DrawX=13, DrawY=6, ROM returns 10 → rom_addr=308224+53=308277; layer 10, data 10.
- pix_start at cycle 2 of a pacman fetch → overrun=1, no pix_valid for the first pixel; the second pixel resolves normally; Reset clears overrun.
